matrix_scan_reader: RTL and testbench
=====================================

MATRIX_SCAN_READER -- requirements
Module: matrix_scan_reader

Interface
REQ-001 Parameter SCAN_DIV, default 4, meaning settle cycles per coordinate before the returned code is sampled (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request one frame scan; sampled only in IDLE.
REQ-005 mdc  output  3  column coordinate driven to the coordinate-to-select logic.
REQ-006 mdl  output  3  row coordinate driven to the coordinate-to-select logic.
REQ-007 sel_in  input  3  returned 3-bit demux select code for the current (mdc, mdl).
REQ-008 row_data  output  24  captured codes for one row; column c occupies bits [3c+2:3c].
REQ-009 row_idx  output  3  row index of row_data.
REQ-010 row_valid  output  1  row_data and row_idx are valid.
REQ-011 row_ready  input  1  downstream accepts the row.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the last row is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE, EMIT, DONE.
REQ-015 IDLE: start=1 -> DRIVE with mdl=0, mdc=0, and the settle counter loaded with SCAN_DIV-1.
REQ-016 DRIVE: mdc and mdl are held constant, and the counter decrements each cycle; at count 0 -> SAMPLE.
REQ-017 SAMPLE (one cycle): sel_in is written into row_data slot mdc; if mdc<7, increment mdc, reload the counter, -> DRIVE; if mdc=7 -> EMIT.
REQ-018 Latency: first-coordinate capture occurs SCAN_DIV+1 cycles after start is accepted; a full row takes 8*(SCAN_DIV+1) cycles to reach EMIT.
REQ-019 EMIT: row_valid=1, and row_data and row_idx are stable until row_valid&row_ready.
REQ-020 On acceptance with mdl<7: increment mdl, set mdc=0, and -> DRIVE.
REQ-021 On acceptance with mdl=7 -> DONE.
REQ-022 DONE (one cycle): done=1 -> IDLE.
REQ-023 row_ready while not in EMIT SHALL be ignored.
REQ-024 start outside IDLE SHALL be ignored; it SHALL not be queued.
REQ-025 Coordinate counters SHALL wrap 7 -> 0 only via the explicit mdc=0 and mdl reset to 0 on the next start, never by overflow.
REQ-026 row_idx SHALL equal mdl during EMIT.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL enter IDLE with mdc=0, mdl=0, row_data=0, row_idx=0, row_valid=0, busy=0, done=0, counter=0.
REQ-028 Reset mid-scan SHALL abandon the frame; no partial row_valid or done SHALL follow.

Configuration
REQ-029 Macro SCAN_CONTINUOUS_EN: when defined, DONE SHALL go directly to DRIVE with mdl=0, mdc=0 (scanning free-runs after one start, and done still pulses every frame); when undefined, DONE -> IDLE per REQ-022.

Structure
REQ-030 Package matrix_scan_pkg SHALL hold the FSM state enum, COORD_W=3, CODE_W=3, NCOLS=8, NROWS=8.
REQ-031 The settle counter SHALL be a sub-module scan_prescaler (load, decrement, zero flag).

Verification
REQ-032 Reset with SCAN_DIV=4, then start for 1 cycle -> busy=1 next cycle; the first SAMPLE is 5 cycles after start acceptance; row_valid rises after 40 cycles with row_idx=0.
REQ-033 Model sel_in = mdc^mdl, with row_ready held 1 -> 8 rows; row r has slot c = c^r (row 3 = 24'o45670123 in column order 7..0), then a single done pulse, then IDLE.
REQ-034 Hold row_ready=0 for 10 cycles in EMIT of row 2 -> row_data, row_idx=2, mdc and mdl are stable; no further sampling occurs; acceptance resumes the scan with row 3.
REQ-035 Pulse start in DRIVE of row 5 -> no effect; the frame completes once with exactly one done.
REQ-036 Assert rst_n=0 during SAMPLE of row 4, col 6 -> next cycle all outputs are at reset values; no row_valid until a new start.
REQ-037 With SCAN_CONTINUOUS_EN defined and one start -> 3 frames yield 3 done pulses, and row_idx sequence 0..7 repeats with busy constantly 1.

Source files
------------

// File: rtl/matrix_scan_pkg.sv
// Shared types and sizing for the matrix scan reader.
// Used by matrix_scan_reader (SCAN_CONTINUOUS_EN selects free-running frames there).
package matrix_scan_pkg;

  localparam int COORD_W = 3;
  localparam int CODE_W  = 3;
  localparam int NCOLS   = 8;
  localparam int NROWS   = 8;
  localparam int ROW_W   = NCOLS * CODE_W;
  localparam int CNT_W   = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [ROW_W-1:0]   row_t;

  localparam coord_t COL_LAST = coord_t'(NCOLS - 1);
  localparam coord_t ROW_LAST = coord_t'(NROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EMIT,
    ST_DONE
  } scan_state_t;

  // Reload value for the settle counter; a full coordinate costs div+1 cycles
  // (div cycles in DRIVE counting load..0, then one SAMPLE cycle).
  function automatic logic [CNT_W-1:0] settle_load(input int div);
    return CNT_W'(div - 1);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Settle down-counter for the matrix scan reader: load, decrement, zero flag.
module scan_prescaler
  import matrix_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/matrix_scan_reader.sv
// Matrix scan reader: walks an 8x8 coordinate grid, lets each coordinate settle
// for SCAN_DIV cycles, samples the returned select code and emits one 24-bit
// row per handshake.
// Build option: define SCAN_CONTINUOUS_EN to restart a new frame straight from
// DONE instead of returning to IDLE.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// DRIVE  | coordinate held, settle counter running
// SAMPLE | capture sel_in into slot mdc, advance column
// EMIT   | row_valid high, waiting for row_ready
// DONE   | one-cycle done pulse at end of frame
module matrix_scan_reader
  import matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [COORD_W-1:0] mdc,
  output logic [COORD_W-1:0] mdl,
  input  logic [CODE_W-1:0]  sel_in,
  output logic [ROW_W-1:0]   row_data,
  output logic [COORD_W-1:0] row_idx,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SCAN_DIV);

  scan_state_t state;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_zero;

  scan_prescaler u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Counter is reloaded on every transition into DRIVE, counts down inside it.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE:   cnt_load = start;
      ST_DRIVE:  cnt_dec  = !cnt_zero;
      ST_SAMPLE: cnt_load = (mdc != COL_LAST);
      ST_EMIT:   cnt_load = row_ready && (mdl != ROW_LAST);
`ifdef SCAN_CONTINUOUS_EN
      ST_DONE:   cnt_load = 1'b1;
`else
      ST_DONE:   cnt_load = 1'b0;
`endif
      default:   cnt_load = 1'b0;
    endcase
  end

  // Scan sequencer with registered coordinate, row and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mdc       <= '0;
      mdl       <= '0;
      row_data  <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DRIVE;
            mdc   <= '0;
            mdl   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_DRIVE: begin
          if (cnt_zero) begin
            state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          for (int c = 0; c < NCOLS; c++) begin
            if (mdc == coord_t'(c)) begin
              row_data[c*CODE_W +: CODE_W] <= sel_in;
            end
          end
          if (mdc != COL_LAST) begin
            mdc   <= mdc + 1'b1;
            state <= ST_DRIVE;
          end else begin
            state     <= ST_EMIT;
            row_valid <= 1'b1;
            row_idx   <= mdl;
          end
        end

        ST_EMIT: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            if (mdl != ROW_LAST) begin
              mdl   <= mdl + 1'b1;
              mdc   <= '0;
              state <= ST_DRIVE;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
`ifdef SCAN_CONTINUOUS_EN
          state <= ST_DRIVE;
          mdc   <= '0;
          mdl   <= '0;
`else
          state <= ST_IDLE;
          busy  <= 1'b0;
`endif
        end

        default: begin
          state     <= ST_IDLE;
          row_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_reader.sv
// Directed bench for matrix_scan_reader with SCAN_DIV=4 and sel_in = mdc ^ mdl.
module tb_matrix_scan_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdc;
  logic [2:0]  mdl;
  logic [2:0]  sel_in;
  logic [23:0] row_data;
  logic [2:0]  row_idx;
  logic        row_valid;
  logic        row_ready;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;
  int done_cnt;
  int busy_low_cnt;
  logic mon_busy;

  matrix_scan_reader #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mdc       (mdc),
    .mdl       (mdl),
    .sel_in    (sel_in),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .busy      (busy),
    .done      (done)
  );

  assign sel_in = mdc ^ mdl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (mon_busy && busy !== 1'b1) busy_low_cnt <= busy_low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_row(input int r);
    logic [23:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[c*3 +: 3] = 3'(c ^ r);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge at which row_valid is first seen high.
  task automatic wait_row(input int r);
    int k;
    for (k = 0; k < 200; k++) begin
      tick();
      if (row_valid === 1'b1) break;
    end
    check($sformatf("row%0d_valid", r), {31'd0, row_valid}, 32'd1);
    check($sformatf("row%0d_idx", r), {29'd0, row_idx}, 32'(r));
    check($sformatf("row%0d_data", r), {8'd0, row_data}, {8'd0, exp_row(r)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int d0;
    logic seen;
    n_cmp = 0;
    n_bad = 0;
    done_cnt = 0;
    busy_low_cnt = 0;
    mon_busy = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    row_ready = 1'b1;

    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, row_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_coord", {26'd0, mdl, mdc}, 32'd0);
    check("rst_row", {5'd0, row_idx, row_data}, 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef SCAN_CONTINUOUS_EN
    d0 = done_cnt;
    pulse_start();
    mon_busy = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 8; r++) wait_row(r);
    end
    tick();
    check("cont_done_pulse", {31'd0, done}, 32'd1);
    tick();
    mon_busy = 1'b0;
    check("cont_done_cnt", 32'(done_cnt - d0), 32'd3);
    check("cont_busy_low", 32'(busy_low_cnt), 32'd0);
`else
    // Frame 1: latency and full frame with row_ready held high.
    d0 = done_cnt;
    pulse_start();
    check("lat_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    check("lat_mdc_pre", {29'd0, mdc}, 32'd0);
    tick();
    check("lat_mdc_post", {29'd0, mdc}, 32'd1);
    repeat (34) tick();
    check("lat_valid_pre", {31'd0, row_valid}, 32'd0);
    tick();
    check("lat_valid", {31'd0, row_valid}, 32'd1);
    check("lat_idx", {29'd0, row_idx}, 32'd0);
    check("lat_data", {8'd0, row_data}, {8'd0, exp_row(0)});
    for (int r = 1; r < 8; r++) wait_row(r);
    tick();
    check("f1_done_pulse", {31'd0, done}, 32'd1);
    check("f1_busy_in_done", {31'd0, busy}, 32'd1);
    tick();
    check("f1_done_low", {31'd0, done}, 32'd0);
    check("f1_idle", {31'd0, busy}, 32'd0);
    check("f1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Frame 2: stall on row 2, ignored start in row 5.
    d0 = done_cnt;
    pulse_start();
    wait_row(0);
    wait_row(1);
    tick();
    row_ready = 1'b0;
    wait_row(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", {31'd0, row_valid}, 32'd1);
      check("stall_data", {8'd0, row_data}, {8'd0, exp_row(2)});
      check("stall_idx", {29'd0, row_idx}, 32'd2);
      check("stall_coord", {26'd0, mdl, mdc}, {26'd0, 3'd2, 3'd7});
    end
    row_ready = 1'b1;
    wait_row(3);
    check("row3_hand", {8'd0, row_data}, {8'd0, 24'o45670123});
    wait_row(4);
    tick();
    check("r5_mdl", {29'd0, mdl}, 32'd5);
    pulse_start();
    for (int r = 5; r < 8; r++) wait_row(r);
    repeat (30) tick();
    check("f2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("f2_no_requeue", {31'd0, busy}, 32'd0);

    // Frame 3: reset during SAMPLE of row 4, column 6.
    d0 = done_cnt;
    pulse_start();
    for (int r = 0; r < 4; r++) wait_row(r);
    tick();
    check("rs_row4_start", {26'd0, mdl, mdc}, {26'd0, 3'd4, 3'd0});
    repeat (34) tick();
    check("rs_at_col6", {26'd0, mdl, mdc}, {26'd0, 3'd4, 3'd6});
    rst_n = 1'b0;
    tick();
    check("rs_coord", {26'd0, mdl, mdc}, 32'd0);
    check("rs_row", {5'd0, row_idx, row_data}, 32'd0);
    check("rs_flags", {29'd0, row_valid, busy, done}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (row_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("rs_quiet", {31'd0, seen}, 32'd0);
    check("rs_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_start();
    wait_row(0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
